// File: rtl/pipe_elastic_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_elastic_buf
//  Purpose  : DEPTH-entry elastic stage buffer with valid/ready handshake,
//             synchronous flush and optional fall-through when empty.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_elastic_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int PASS  = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("pipe_elastic_buf: WIDTH must be >= 1");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("pipe_elastic_buf: DEPTH must be >= 1");
        end
    endgenerate

    logic [c_cnt_w-1:0] count_q, count_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_stored_valid;
    logic w_push;
    logic w_pop;
    logic w_write;
    logic w_read;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_last) ? '0 : ptr + c_ptr_w'(1);
    endfunction

    assign w_full   = (count_q == c_cnt_w'(DEPTH));
    assign w_empty  = (count_q == '0);
    assign in_ready = !w_full && !flush && resetn;

    generate
        if (PASS != 0) begin : g_fall_through
            assign w_bypass = w_empty && in_valid && !flush && resetn;
        end else begin : g_registered
            assign w_bypass = 1'b0;
        end
    endgenerate

    assign w_stored_valid = !w_empty && !flush;
    assign out_valid      = w_stored_valid || w_bypass;

    always_comb begin
        out_data = '0;
        if (w_stored_valid) begin
            out_data = mem_q[rd_ptr_q];
        end else if (w_bypass) begin
            out_data = in_data;
        end
    end

    assign w_push  = in_valid && in_ready;
    assign w_pop   = out_valid && out_ready;
    // A bypassed item consumed in the same cycle never touches storage.
    assign w_write = w_push && !(w_bypass && out_ready);
    assign w_read  = w_pop && !w_empty;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (w_write) begin
                wr_ptr_d = f_inc(wr_ptr_q);
            end
            if (w_read) begin
                rd_ptr_d = f_inc(rd_ptr_q);
            end
            case ({w_write, w_read})
                2'b10:   count_d = count_q + c_cnt_w'(1);
                2'b01:   count_d = count_q - c_cnt_w'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign count = count_q;
    assign full  = w_full;
    assign empty = w_empty;

endmodule
`default_nettype wire
